// File: rtl/joybus_poll_sched.sv
// joybus_poll_sched
// Command sequencer in front of the JOYBUS TX/RX pair. After reset it issues one
// INIT_CMD. It then issues POLL_CMD every POLL_PERIOD cycles while polling is
// enabled, and interleaves one-shot host commands; the host wins a tie. Each
// transaction waits for the TX stop bit, then for the RX reply or a timeout, then
// holds the bus idle for GAP_CYCLES before the next command is accepted.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   poll_en_i        1 = periodic polling enabled
//   host_req_i       level request for a one-shot command, held until host_ack_o
//   host_cmd_i       host command byte, captured on the host_ack_o cycle
//   host_ack_o       1-cycle pulse: host command accepted
//   tx_cmd_data_o    command byte to TX, stable from ISSUE until tx_done_i
//   tx_cmd_rdy_o     1-cycle start pulse to TX
//   tx_done_i        1-cycle pulse from TX: stop bit finished
//   rx_done_in_i     1-cycle pulse from RX: reply received
//   tx_rx_done_o     to TX: reply (in RX_WAIT) or timeout
//   resp_valid_o     1-cycle pulse: transaction finished
//   resp_src_o       0=init 1=poll 2=host, valid with resp_valid_o
//   resp_timeout_o   1 = finished by timeout, valid with resp_valid_o
//   link_ok_o        1 after a replied transaction, 0 after a timed-out one
//   err_cnt_o        timeout count, saturates at 255
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for a host request or a pending poll
// ISSUE     | start pulse to TX (exactly one cycle)
// TX_WAIT   | command shifting out, wait for tx_done
// RX_WAIT   | reply window, timer runs toward the timeout
// GAP       | bus recovery before the next transaction

module joybus_poll_sched #(
    parameter int unsigned POLL_PERIOD = 400000,
    parameter int unsigned RX_TIMEOUT  = 2400,
    parameter int unsigned GAP_CYCLES  = 48,
    parameter logic [7:0]  POLL_CMD    = 8'h01,
    parameter logic [7:0]  INIT_CMD    = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_en_i,
    input  logic       host_req_i,
    input  logic [7:0] host_cmd_i,
    output logic       host_ack_o,
    output logic [7:0] tx_cmd_data_o,
    output logic       tx_cmd_rdy_o,
    input  logic       tx_done_i,
    input  logic       rx_done_in_i,
    output logic       tx_rx_done_o,
    output logic       resp_valid_o,
    output logic [1:0] resp_src_o,
    output logic       resp_timeout_o,
    output logic       link_ok_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned PCW  = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned TMAX = (RX_TIMEOUT > GAP_CYCLES) ? RX_TIMEOUT : GAP_CYCLES;
    localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    // All timers are down-counters loaded with (length - 1) and finishing at zero.
    localparam logic [PCW-1:0] PER_RELOAD = PCW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0]  RX_RELOAD  = TW'(RX_TIMEOUT - 1);
    localparam logic [TW-1:0]  GAP_RELOAD = TW'(GAP_CYCLES - 1);

    localparam logic [1:0] SRC_INIT = 2'd0;
    localparam logic [1:0] SRC_POLL = 2'd1;
    localparam logic [1:0] SRC_HOST = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_TX_WAIT,
        S_RX_WAIT,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [1:0]     src_q, src_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [PCW-1:0] per_cnt_q, per_cnt_d;
    logic           poll_pend_q, poll_pend_d;
    logic           link_ok_q, link_ok_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           per_wrap;

    // Period counter: free-runs only while polling is enabled and restarts
    // from the beginning of a period whenever polling is switched off.
    always_comb begin
        per_wrap  = 1'b0;
        per_cnt_d = per_cnt_q;
        if (!poll_en_i) begin
            per_cnt_d = PER_RELOAD;
        end else if (per_cnt_q == '0) begin
            per_wrap  = 1'b1;
            per_cnt_d = PER_RELOAD;
        end else begin
            per_cnt_d = per_cnt_q - PCW'(1);
        end
    end

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        src_d          = src_q;
        timer_d        = timer_q;
        poll_pend_d    = poll_pend_q;
        link_ok_d      = link_ok_q;
        err_cnt_d      = err_cnt_q;
        host_ack_o     = 1'b0;
        tx_cmd_rdy_o   = 1'b0;
        tx_rx_done_o   = 1'b0;
        resp_valid_o   = 1'b0;
        resp_timeout_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (host_req_i) begin
                    host_ack_o = 1'b1;
                    cmd_d      = host_cmd_i;
                    src_d      = SRC_HOST;
                    state_d    = S_ISSUE;
                end else if (poll_pend_q) begin
                    cmd_d       = POLL_CMD;
                    src_d       = SRC_POLL;
                    poll_pend_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_cmd_rdy_o = 1'b1;
                state_d      = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_done_i) begin
                    timer_d = RX_RELOAD;
                    state_d = S_RX_WAIT;
                end
            end
            S_RX_WAIT: begin
                // A reply arriving on the timeout cycle still counts as a reply.
                if (rx_done_in_i) begin
                    tx_rx_done_o = 1'b1;
                    resp_valid_o = 1'b1;
                    link_ok_d    = 1'b1;
                    timer_d      = GAP_RELOAD;
                    state_d      = S_GAP;
                end else if (timer_q == '0) begin
                    tx_rx_done_o   = 1'b1;
                    resp_valid_o   = 1'b1;
                    resp_timeout_o = 1'b1;
                    link_ok_d      = 1'b0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    timer_d = GAP_RELOAD;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A wrap in the same cycle a poll is taken starts a fresh period, so it
        // must survive the clear above. Wraps while already pending collapse.
        if (per_wrap) begin
            poll_pend_d = 1'b1;
        end
        if (!poll_en_i) begin
            poll_pend_d = 1'b0;
        end

        // Reset parks the FSM in ISSUE; keep every pulse quiet until rst drops.
        if (rst) begin
            host_ack_o     = 1'b0;
            tx_cmd_rdy_o   = 1'b0;
            tx_rx_done_o   = 1'b0;
            resp_valid_o   = 1'b0;
            resp_timeout_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ISSUE;
            cmd_q       <= INIT_CMD;
            src_q       <= SRC_INIT;
            timer_q     <= '0;
            per_cnt_q   <= PER_RELOAD;
            poll_pend_q <= 1'b0;
            link_ok_q   <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            src_q       <= src_d;
            timer_q     <= timer_d;
            per_cnt_q   <= per_cnt_d;
            poll_pend_q <= poll_pend_d;
            link_ok_q   <= link_ok_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign tx_cmd_data_o = cmd_q;
    assign resp_src_o    = src_q;
    assign link_ok_o     = link_ok_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_joybus_poll_sched.sv
// Testbench for joybus_poll_sched. The bench plays the TX/RX pair and the host,
// and predicts timing, command bytes and status from the behavioural rules
// (poll schedule arithmetic, reply/timeout latency, saturating error count).
module tb_joybus_poll_sched;

    localparam int P   = 1000;
    localparam int RXT = 120;
    localparam int G   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       poll_en;
    logic       host_req;
    logic [7:0] host_cmd;
    logic       host_ack;
    logic [7:0] tx_cmd_data;
    logic       tx_cmd_rdy;
    logic       tx_done;
    logic       rx_done_in;
    logic       tx_rx_done;
    logic       resp_valid;
    logic [1:0] resp_src;
    logic       resp_timeout;
    logic       link_ok;
    logic [7:0] err_cnt;

    joybus_poll_sched #(
        .POLL_PERIOD (P),
        .RX_TIMEOUT  (RXT),
        .GAP_CYCLES  (G),
        .POLL_CMD    (8'h01),
        .INIT_CMD    (8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .poll_en_i      (poll_en),
        .host_req_i     (host_req),
        .host_cmd_i     (host_cmd),
        .host_ack_o     (host_ack),
        .tx_cmd_data_o  (tx_cmd_data),
        .tx_cmd_rdy_o   (tx_cmd_rdy),
        .tx_done_i      (tx_done),
        .rx_done_in_i   (rx_done_in),
        .tx_rx_done_o   (tx_rx_done),
        .resp_valid_o   (resp_valid),
        .resp_src_o     (resp_src),
        .resp_timeout_o (resp_timeout),
        .link_ok_o      (link_ok),
        .err_cnt_o      (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int errs   = 0;
    int checks = 0;
    bit drop_req = 1'b0;

    // observations from the last transaction
    bit         o_ok, o_ack, o_to, o_trx, o_link;
    int         o_ack_cyc, o_issue_cyc, o_resp_cyc, o_resp_k;
    logic [7:0] o_cmd, o_cmd_done, o_err;
    logic [1:0] o_src;

    // reference model state
    int m_err;
    bit m_link;

    function automatic int sat_err(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
        tx_done    = 1'b0;
        rx_done_in = 1'b0;
        if (drop_req) begin
            host_req = 1'b0;
            host_cmd = 8'($urandom);
            drop_req = 1'b0;
        end
        #1;
    endtask

    // Plays host/TX/RX for one transaction. rx_lat < 1 means no reply;
    // rst_at > 0 asserts rst in that RX_WAIT cycle and returns.
    task automatic run_txn(input int tx_lat, input int rx_lat, input bit post_req,
                           input logic [7:0] post_cmd, input int rst_at);
        o_ok = 1'b0; o_ack = 1'b0; o_to = 1'b0; o_trx = 1'b0; o_resp_k = -1;
        o_src = 2'b11; o_link = 1'bx; o_err = 8'hxx;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) next();
            #1;
            if (host_ack === 1'b1) begin
                o_ack = 1'b1; o_ack_cyc = cyc_n; drop_req = 1'b1;
            end
            if (tx_cmd_rdy === 1'b1) begin
                o_ok = 1'b1; o_issue_cyc = cyc_n; o_cmd = tx_cmd_data;
                break;
            end
        end
        if (!o_ok) return;
        if (post_req) begin
            host_req = 1'b1;
            host_cmd = post_cmd;
        end
        next();
        repeat (tx_lat) next();
        tx_done = 1'b1;
        #1;
        o_cmd_done = tx_cmd_data;
        for (int k = 1; k <= RXT + 4; k++) begin
            next();
            if (rst_at > 0 && k == rst_at) begin
                rst = 1'b1;
                return;
            end
            if (k == rx_lat) rx_done_in = 1'b1;
            #1;
            if (resp_valid === 1'b1) begin
                o_resp_k = k; o_resp_cyc = cyc_n; o_src = resp_src;
                o_to = resp_timeout; o_trx = tx_rx_done;
                break;
            end
        end
        if (o_resp_k < 0) begin
            o_ok = 1'b0;
            return;
        end
        next();
        #1;
        o_link = link_ok;
        o_err  = err_cnt;
    endtask

    task automatic test_reset();
        int rel;
        rst = 1'b1; poll_en = 1'b0; host_req = 1'b0; host_cmd = 8'h00;
        tx_done = 1'b0; rx_done_in = 1'b0;
        next(); next(); next();
        rx_done_in = 1'b1;
        #1;
        checks++; if (tx_cmd_rdy !== 1'b0) begin errs++; $display("FAIL reset_rdy: got %0b want 0", tx_cmd_rdy); end
        checks++; if (tx_cmd_data !== 8'h00) begin errs++; $display("FAIL reset_data: got %0h want 00", tx_cmd_data); end
        checks++; if (link_ok !== 1'b0) begin errs++; $display("FAIL reset_link: got %0b want 0", link_ok); end
        checks++; if (err_cnt !== 8'h00) begin errs++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        checks++; if ({resp_valid, tx_rx_done, host_ack} !== 3'b000) begin errs++; $display("FAIL reset_pulses: got %b want 000", {resp_valid, tx_rx_done, host_ack}); end
        next();
        rst = 1'b0;
        rel = cyc_n;
        run_txn($urandom_range(0, 10), 100, 1'b0, 8'h00, 0);
        checks++; if (!o_ok || o_issue_cyc != rel) begin errs++; $display("FAIL init_issue: ok=%0b cycle %0d want %0d", o_ok, o_issue_cyc, rel); end
        checks++; if (o_cmd !== 8'h00) begin errs++; $display("FAIL init_cmd: got %0h want 00", o_cmd); end
        checks++; if (o_src !== 2'd0 || o_to !== 1'b0) begin errs++; $display("FAIL init_resp: src=%0d to=%0b want src=0 to=0", o_src, o_to); end
        checks++; if (o_resp_k != 100 || o_trx !== 1'b1) begin errs++; $display("FAIL init_latency: k=%0d trx=%0b want k=100 trx=1", o_resp_k, o_trx); end
        m_err = 0; m_link = 1'b1;
        checks++; if (o_link !== m_link || o_err !== 8'(sat_err(m_err))) begin errs++; $display("FAIL init_status: link=%0b err=%0d want link=1 err=0", o_link, o_err); end
    endtask

    task automatic test_poll();
        int s, rxl, exp_issue;
        next();
        poll_en = 1'b1;
        s = cyc_n;
        for (int n = 0; n < 4; n++) begin
            rxl = (n == 0) ? 1 : (n == 1) ? RXT - 1 : int'($urandom_range(2, RXT - 2));
            run_txn($urandom_range(0, 30), rxl, 1'b0, 8'h00, 0);
            exp_issue = s + P + 1 + n * P;
            checks++; if (!o_ok || o_issue_cyc != exp_issue) begin errs++; $display("FAIL poll_issue[%0d]: ok=%0b cycle %0d want %0d", n, o_ok, o_issue_cyc, exp_issue); end
            checks++; if (o_cmd !== 8'h01 || o_src !== 2'd1) begin errs++; $display("FAIL poll_cmd[%0d]: cmd=%0h src=%0d want 01/1", n, o_cmd, o_src); end
            checks++; if (o_to !== 1'b0 || o_resp_k != rxl) begin errs++; $display("FAIL poll_resp[%0d]: to=%0b k=%0d want 0/%0d", n, o_to, o_resp_k, rxl); end
            checks++; if (o_link !== 1'b1 || o_ack !== 1'b0) begin errs++; $display("FAIL poll_status[%0d]: link=%0b ack=%0b want 1/0", n, o_link, o_ack); end
        end
    endtask

    task automatic test_priority();
        int s2, rp, rh;
        next(); poll_en = 1'b0;
        next(); poll_en = 1'b1;
        s2 = cyc_n;
        // hold TX long enough that the next period elapses mid-transaction
        run_txn(P + 20, $urandom_range(1, RXT - 1), 1'b1, 8'h41, 0);
        rp = o_resp_cyc;
        checks++; if (!o_ok || o_issue_cyc != s2 + P + 1 || o_cmd !== 8'h01) begin errs++; $display("FAIL prio_first_poll: ok=%0b cycle %0d cmd %0h want %0d/01", o_ok, o_issue_cyc, o_cmd, s2 + P + 1); end
        run_txn($urandom_range(0, 5), $urandom_range(1, RXT - 1), 1'b0, 8'h00, 0);
        rh = o_resp_cyc;
        checks++; if (o_ack !== 1'b1 || o_ack_cyc != rp + G + 1) begin errs++; $display("FAIL prio_ack: ack=%0b cycle %0d want cycle %0d", o_ack, o_ack_cyc, rp + G + 1); end
        checks++; if (!o_ok || o_issue_cyc != rp + G + 2) begin errs++; $display("FAIL prio_host_issue: cycle %0d want %0d", o_issue_cyc, rp + G + 2); end
        checks++; if (o_cmd !== 8'h41 || o_cmd_done !== 8'h41 || o_src !== 2'd2) begin errs++; $display("FAIL prio_host_cmd: cmd=%0h at_done=%0h src=%0d want 41/41/2", o_cmd, o_cmd_done, o_src); end
        run_txn($urandom_range(0, 5), $urandom_range(1, RXT - 1), 1'b0, 8'h00, 0);
        checks++; if (!o_ok || o_issue_cyc != rh + G + 2) begin errs++; $display("FAIL prio_poll_after: cycle %0d want %0d", o_issue_cyc, rh + G + 2); end
        checks++; if (o_cmd !== 8'h01 || o_src !== 2'd1 || o_ack !== 1'b0) begin errs++; $display("FAIL prio_poll_cmd: cmd=%0h src=%0d ack=%0b want 01/1/0", o_cmd, o_src, o_ack); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cmd;
        int rxl, prev_resp, sel;
        bit exp_to;
        next();
        poll_en = 1'b0;
        prev_resp = 0;
        for (int n = 0; n < 10; n++) begin
            cmd = 8'($urandom);
            sel = $urandom_range(0, 4);
            rxl = (sel == 0) ? -1 : (sel == 1) ? 1 : (sel == 2) ? RXT - 1 : int'($urandom_range(2, RXT - 2));
            host_req = 1'b1;
            host_cmd = cmd;
            run_txn($urandom_range(0, 15), rxl, 1'b0, 8'h00, 0);
            exp_to = (rxl < 1);
            if (exp_to) m_err++;
            m_link = !exp_to;
            checks++; if (!o_ok || o_ack !== 1'b1 || o_ack_cyc != o_issue_cyc - 1) begin errs++; $display("FAIL b2b_ack[%0d]: ok=%0b ack=%0b ack_cyc %0d issue %0d", n, o_ok, o_ack, o_ack_cyc, o_issue_cyc); end
            if (n > 0) begin
                checks++; if (o_issue_cyc != prev_resp + G + 2) begin errs++; $display("FAIL b2b_gap[%0d]: issue %0d want %0d", n, o_issue_cyc, prev_resp + G + 2); end
            end
            checks++; if (o_cmd !== cmd || o_cmd_done !== cmd || o_src !== 2'd2) begin errs++; $display("FAIL b2b_cmd[%0d]: cmd=%0h at_done=%0h src=%0d want %0h/2", n, o_cmd, o_cmd_done, o_src, cmd); end
            checks++; if (o_to !== exp_to || o_trx !== 1'b1 || o_resp_k != (exp_to ? RXT : rxl)) begin errs++; $display("FAIL b2b_resp[%0d]: to=%0b trx=%0b k=%0d want to=%0b k=%0d", n, o_to, o_trx, o_resp_k, exp_to, exp_to ? RXT : rxl); end
            checks++; if (o_link !== m_link || o_err !== 8'(sat_err(m_err))) begin errs++; $display("FAIL b2b_status[%0d]: link=%0b err=%0d want %0b/%0d", n, o_link, o_err, m_link, sat_err(m_err)); end
            prev_resp = o_resp_cyc;
        end
    endtask

    task automatic test_timeout();
        host_req = 1'b1;
        host_cmd = 8'h5A;
        run_txn(2, -1, 1'b0, 8'h00, 0);
        m_err++;
        m_link = 1'b0;
        checks++; if (!o_ok || o_resp_k != RXT) begin errs++; $display("FAIL timeout_latency: ok=%0b k=%0d want %0d", o_ok, o_resp_k, RXT); end
        checks++; if (o_to !== 1'b1 || o_trx !== 1'b1) begin errs++; $display("FAIL timeout_flags: to=%0b trx=%0b want 1/1", o_to, o_trx); end
        checks++; if (o_link !== 1'b0 || o_err !== 8'(sat_err(m_err))) begin errs++; $display("FAIL timeout_status: link=%0b err=%0d want 0/%0d", o_link, o_err, sat_err(m_err)); end
    endtask

    task automatic test_err_sat();
        while (m_err < 300) begin
            host_req = 1'b1;
            host_cmd = 8'($urandom);
            run_txn($urandom_range(0, 3), -1, 1'b0, 8'h00, 0);
            m_err++;
            checks++; if (!o_ok || o_to !== 1'b1 || o_err !== 8'(sat_err(m_err))) begin errs++; $display("FAIL sat_step[%0d]: ok=%0b to=%0b err=%0d want 1/%0d", m_err, o_ok, o_to, o_err, sat_err(m_err)); end
        end
        checks++; if (o_err !== 8'd255) begin errs++; $display("FAIL sat_hold: got %0d want 255", o_err); end
        host_req = 1'b1;
        host_cmd = 8'h33;
        run_txn(1, RXT, 1'b0, 8'h00, 0);
        m_link = 1'b1;
        checks++; if (!o_ok || o_resp_k != RXT || o_to !== 1'b0) begin errs++; $display("FAIL reply_on_timeout: ok=%0b k=%0d to=%0b want %0d/0", o_ok, o_resp_k, o_to, RXT); end
        checks++; if (o_link !== 1'b1 || o_err !== 8'd255) begin errs++; $display("FAIL reply_on_timeout_status: link=%0b err=%0d want 1/255", o_link, o_err); end
    endtask

    task automatic test_reset_mid();
        int s3, r;
        next();
        poll_en = 1'b1;
        s3 = cyc_n;
        host_req = 1'b1;
        host_cmd = 8'h77;
        // long TX makes a poll pending before the reset lands in RX_WAIT
        run_txn(P + 10, -1, 1'b0, 8'h00, 5);
        checks++; if (!o_ok || o_issue_cyc > s3 + P - 20) begin errs++; $display("FAIL mid_setup: ok=%0b issue %0d", o_ok, o_issue_cyc); end
        next();
        rst = 1'b0;
        r = cyc_n;
        #1;
        checks++; if (err_cnt !== 8'h00 || link_ok !== 1'b0) begin errs++; $display("FAIL mid_rst_status: err=%0d link=%0b want 0/0", err_cnt, link_ok); end
        run_txn($urandom_range(0, 5), $urandom_range(1, RXT - 1), 1'b0, 8'h00, 0);
        m_err = 0; m_link = 1'b1;
        checks++; if (!o_ok || o_issue_cyc != r || o_cmd !== 8'h00 || o_src !== 2'd0) begin errs++; $display("FAIL mid_init: ok=%0b cycle %0d cmd %0h src %0d want %0d/00/0", o_ok, o_issue_cyc, o_cmd, o_src, r); end
        checks++; if (o_err !== 8'd0 || o_link !== 1'b1) begin errs++; $display("FAIL mid_init_status: err=%0d link=%0b want 0/1", o_err, o_link); end
        run_txn(0, 3, 1'b0, 8'h00, 0);
        checks++; if (!o_ok || o_issue_cyc != r + P + 1 || o_cmd !== 8'h01) begin errs++; $display("FAIL mid_no_stale_poll: cycle %0d cmd %0h want %0d/01", o_issue_cyc, o_cmd, r + P + 1); end
    endtask

    task automatic test_no_poll();
        int rdy_n, resp_n, trx_n;
        rdy_n = 0; resp_n = 0; trx_n = 0;
        next();
        poll_en = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            next();
            if ($urandom_range(0, 7) == 0) rx_done_in = 1'b1;
            #1;
            if (tx_cmd_rdy === 1'b1) rdy_n++;
            if (resp_valid === 1'b1) resp_n++;
            if (tx_rx_done === 1'b1) trx_n++;
        end
        checks++; if (rdy_n != 0) begin errs++; $display("FAIL no_poll_issue: %0d issues want 0", rdy_n); end
        checks++; if (resp_n != 0 || trx_n != 0) begin errs++; $display("FAIL stray_rx_done: resp=%0d trx=%0d want 0/0", resp_n, trx_n); end
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_poll();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_err_sat();
        test_reset_mid();
        test_no_poll();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
